// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline stage buffer: a DEPTH-entry FIFO of control/data pairs with
// valid/ready handshake, synchronous flush, zero-gated bubbles and a saturating bubble counter.
module pipe_stage_buf #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             bubble_count
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [OCC_W-1:0] FULL     = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CTRL_W-1:0] ctrlMem_q [DEPTH];
    logic [DATA_W-1:0] dataMem_q [DEPTH];

    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // out_ready feeds in_ready combinationally so a full buffer can pop and refill in one cycle.
    assign in_ready  = !flush && ((count_q != FULL) || out_ready);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_ctrl     = out_valid ? ctrlMem_q[rdPtr_q] : '0;
    assign out_data     = out_valid ? dataMem_q[rdPtr_q] : '0;
    assign occupancy    = count_q;
    assign bubble_count = bubbleCnt_q;

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;

        if (flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = advance(wrPtr_q);
            end
            if (pop) begin
                rdPtr_d = advance(rdPtr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Flush leaves the bubble counter alone; only reset clears it.
    always_comb begin
        bubbleCnt_d = bubbleCnt_q;
        if (out_ready && !out_valid && (bubbleCnt_q != CNT_MAX)) begin
            bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= '0;
            bubbleCnt_q <= '0;
        end else begin
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctrlMem_q[i] <= '0;
                dataMem_q[i] <= '0;
            end
        end else if (push) begin
            ctrlMem_q[wrPtr_q] <= in_ctrl;
            dataMem_q[wrPtr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: three instances (DEPTH 2, 1 and 3 with a 4-bit
// bubble counter) checked against a queue-based model of the stage buffer.
module tb_pipe_stage_buf;

    localparam int NDUT = 3;

    logic        clk;
    logic        rst_b;
    logic        flush    [NDUT];
    logic        inValid  [NDUT];
    logic        inReady  [NDUT];
    logic [15:0] inCtrl   [NDUT];
    logic [31:0] inData   [NDUT];
    logic        outValid [NDUT];
    logic        outReady [NDUT];
    logic [15:0] outCtrl  [NDUT];
    logic [31:0] outData  [NDUT];
    logic [3:0]  occ      [NDUT];
    logic [15:0] bub      [NDUT];

    int total = 0;
    int bad   = 0;

    // Reference model: the held entries as {ctrl, data} in arrival order.
    logic [47:0] mq [$];
    int          expBub [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        localparam int DEP = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
        localparam int CW  = (g == 2) ? 4 : 16;
        logic [$clog2(DEP+1)-1:0] occW;
        logic [CW-1:0]            bubW;

        pipe_stage_buf #(
            .CTRL_W(16), .DATA_W(32), .DEPTH(DEP), .CNT_W(CW)
        ) u_dut (
            .clk(clk), .rst_b(rst_b), .flush(flush[g]),
            .in_valid(inValid[g]), .in_ready(inReady[g]),
            .in_ctrl(inCtrl[g]), .in_data(inData[g]),
            .out_valid(outValid[g]), .out_ready(outReady[g]),
            .out_ctrl(outCtrl[g]), .out_data(outData[g]),
            .occupancy(occW), .bubble_count(bubW)
        );

        assign occ[g] = 4'(occW);
        assign bub[g] = 16'(bubW);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int depthOf(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 3);
    endfunction

    function automatic int maxBub(input int d);
        return (d == 2) ? 15 : 65535;
    endfunction

    function automatic logic [47:0] headOf();
        return (mq.size() != 0) ? mq[0] : 48'd0;
    endfunction

    // Advance one clock: update the model from the currently driven inputs, then wait.
    task automatic stepCycle(input int d);
        bit popM;
        bit pushM;
        popM  = (mq.size() != 0) && outReady[d];
        pushM = !flush[d] && inValid[d] && ((mq.size() < depthOf(d)) || outReady[d]);
        if (outReady[d] && (mq.size() == 0) && (expBub[d] < maxBub(d))) expBub[d]++;
        if (flush[d]) begin
            mq.delete();
        end else begin
            if (popM) void'(mq.pop_front());
            if (pushM) mq.push_back({inCtrl[d], inData[d]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        for (int d = 0; d < NDUT; d++) begin
            flush[d]    = 1'b0;
            inValid[d]  = 1'b0;
            outReady[d] = 1'b0;
            inCtrl[d]   = '0;
            inData[d]   = '0;
        end
    endtask

    task automatic test_reset();
        idleInputs();
        rst_b = 1'b0;
        #12;
        for (int d = 0; d < NDUT; d++) begin
            total++; if (outValid[d] !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid[%0d]: got %b want 0", d, outValid[d]); end
            total++; if (occ[d] !== 4'd0) begin bad++; $display("[TB] FAIL reset_occ[%0d]: got %0d want 0", d, occ[d]); end
            total++; if (bub[d] !== 16'd0) begin bad++; $display("[TB] FAIL reset_bub[%0d]: got %0d want 0", d, bub[d]); end
            total++; if (outData[d] !== 32'd0) begin bad++; $display("[TB] FAIL reset_data[%0d]: got %h want 0", d, outData[d]); end
        end
        #5;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        for (int d = 0; d < NDUT; d++) expBub[d] = 0;
    endtask

    task automatic test_streaming();
        logic [47:0] h;
        outReady[0] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            inValid[0] = (i <= 5);
            inCtrl[0]  = 16'(i);
            inData[0]  = 32'(i);
            #1;
            h = headOf();
            total++; if (outValid[0] !== ((i >= 2) && (i <= 6))) begin bad++; $display("[TB] FAIL stream_valid c%0d: got %b", i, outValid[0]); end
            total++; if (outCtrl[0] !== h[47:32]) begin bad++; $display("[TB] FAIL stream_ctrl c%0d: got %h want %h", i, outCtrl[0], h[47:32]); end
            total++; if (outData[0] !== h[31:0]) begin bad++; $display("[TB] FAIL stream_data c%0d: got %h want %h", i, outData[0], h[31:0]); end
            total++; if (occ[0] > 4'd1) begin bad++; $display("[TB] FAIL stream_occ c%0d: got %0d want <=1", i, occ[0]); end
            if (i == 6) begin
                total++; if (bub[0] !== 16'd1) begin bad++; $display("[TB] FAIL stream_bub: got %0d want 1", bub[0]); end
            end
            stepCycle(0);
        end
        idleInputs();
    endtask

    task automatic test_backpressure();
        // Per cycle: valid, ready, offered entry, expected in_ready, occupancy, head entry (0 = none).
        int tv [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        int tr [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        int to [8] = '{1, 2, 3, 3, 3, 0, 0, 0};
        int ei [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
        int eo [8] = '{0, 1, 2, 2, 2, 2, 1, 0};
        int eh [8] = '{0, 1, 1, 1, 1, 2, 3, 0};
        logic [31:0] wantData;
        logic [15:0] wantCtrl;
        for (int c = 0; c < 8; c++) begin
            inValid[0]  = (tv[c] != 0);
            outReady[0] = (tr[c] != 0);
            inCtrl[0]   = 16'h00A0 + 16'(to[c]);
            inData[0]   = 32'hB000_0000 + 32'(to[c]);
            #1;
            wantData = (eh[c] != 0) ? 32'hB000_0000 + 32'(eh[c]) : 32'd0;
            wantCtrl = (eh[c] != 0) ? 16'h00A0 + 16'(eh[c]) : 16'd0;
            total++; if (inReady[0] !== (ei[c] != 0)) begin bad++; $display("[TB] FAIL bp_in_ready c%0d: got %b want %0d", c, inReady[0], ei[c]); end
            total++; if (occ[0] !== 4'(eo[c])) begin bad++; $display("[TB] FAIL bp_occ c%0d: got %0d want %0d", c, occ[0], eo[c]); end
            total++; if (outValid[0] !== (eh[c] != 0)) begin bad++; $display("[TB] FAIL bp_valid c%0d: got %b", c, outValid[0]); end
            total++; if (outData[0] !== wantData) begin bad++; $display("[TB] FAIL bp_data c%0d: got %h want %h", c, outData[0], wantData); end
            total++; if (outCtrl[0] !== wantCtrl) begin bad++; $display("[TB] FAIL bp_ctrl c%0d: got %h want %h", c, outCtrl[0], wantCtrl); end
            stepCycle(0);
        end
        idleInputs();
        #1;
        total++; if (bub[0] !== 16'(expBub[0])) begin bad++; $display("[TB] FAIL bp_bub: got %0d want %0d", bub[0], expBub[0]); end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 2; c++) begin
            inValid[0] = 1'b1;
            inCtrl[0]  = 16'h0F00 + 16'(c);
            inData[0]  = 32'hF000_0000 + 32'(c);
            stepCycle(0);
        end
        flush[0]   = 1'b1;
        inValid[0] = 1'b1;
        inCtrl[0]  = 16'h0FFF;
        inData[0]  = 32'hDEAD_BEEF;
        #1;
        total++; if (occ[0] !== 4'd2) begin bad++; $display("[TB] FAIL flush_pre_occ: got %0d want 2", occ[0]); end
        total++; if (inReady[0] !== 1'b0) begin bad++; $display("[TB] FAIL flush_in_ready: got %b want 0", inReady[0]); end
        stepCycle(0);
        idleInputs();
        #1;
        total++; if (occ[0] !== 4'd0) begin bad++; $display("[TB] FAIL flush_occ: got %0d want 0", occ[0]); end
        total++; if (outValid[0] !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %b want 0", outValid[0]); end
        total++; if (outCtrl[0] !== 16'd0) begin bad++; $display("[TB] FAIL flush_ctrl: got %h want 0", outCtrl[0]); end
        total++; if (outData[0] !== 32'd0) begin bad++; $display("[TB] FAIL flush_data: got %h want 0", outData[0]); end
        outReady[0] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++; if (outValid[0] !== 1'b0) begin bad++; $display("[TB] FAIL flush_dropped c%0d: got %b want 0", c, outValid[0]); end
            stepCycle(0);
        end
        idleInputs();
    endtask

    task automatic test_async_reset();
        inValid[0] = 1'b1;
        inCtrl[0]  = 16'h0055;
        inData[0]  = 32'h5555_0001;
        stepCycle(0);
        idleInputs();
        #3;
        rst_b = 1'b0;
        #1;
        total++; if (outValid[0] !== 1'b0) begin bad++; $display("[TB] FAIL areset_valid: got %b want 0", outValid[0]); end
        total++; if (outCtrl[0] !== 16'd0) begin bad++; $display("[TB] FAIL areset_ctrl: got %h want 0", outCtrl[0]); end
        total++; if (outData[0] !== 32'd0) begin bad++; $display("[TB] FAIL areset_data: got %h want 0", outData[0]); end
        total++; if (bub[0] !== 16'd0) begin bad++; $display("[TB] FAIL areset_bub: got %0d want 0", bub[0]); end
        total++; if (occ[0] !== 4'd0) begin bad++; $display("[TB] FAIL areset_occ: got %0d want 0", occ[0]); end
        #3;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        for (int d = 0; d < NDUT; d++) expBub[d] = 0;
    endtask

    task automatic test_legacy();
        int          nextIdx = 1;
        int          rcvCnt  = 0;
        logic [31:0] prevData = '0;
        logic [47:0] h;
        bit          accepted;
        for (int c = 0; (c < 40) && (rcvCnt < 8); c++) begin
            outReady[1] = !((c >= 3) && (c <= 5));
            inValid[1]  = (nextIdx <= 8);
            inCtrl[1]   = 16'h0C00 + 16'(nextIdx);
            inData[1]   = 32'hC000_0000 + 32'(nextIdx);
            #1;
            h = headOf();
            total++; if (outData[1] !== h[31:0]) begin bad++; $display("[TB] FAIL legacy_data c%0d: got %h want %h", c, outData[1], h[31:0]); end
            total++; if (inReady[1] !== ((mq.size() < 1) || outReady[1])) begin bad++; $display("[TB] FAIL legacy_in_ready c%0d: got %b", c, inReady[1]); end
            if ((c >= 4) && (c <= 5)) begin
                total++; if (outData[1] !== prevData) begin bad++; $display("[TB] FAIL legacy_hold c%0d: got %h want %h", c, outData[1], prevData); end
            end
            if (outValid[1] && outReady[1]) begin
                total++; if (outData[1] !== 32'hC000_0000 + 32'(rcvCnt + 1)) begin bad++; $display("[TB] FAIL legacy_order: got %h want %h", outData[1], 32'hC000_0000 + 32'(rcvCnt + 1)); end
                rcvCnt++;
            end
            accepted = inValid[1] && ((mq.size() < 1) || outReady[1]);
            if (accepted) nextIdx++;
            prevData = outData[1];
            stepCycle(1);
        end
        total++; if (rcvCnt != 8) begin bad++; $display("[TB] FAIL legacy_count: got %0d want 8", rcvCnt); end
        idleInputs();
    endtask

    task automatic test_wrap();
        logic [47:0] h;
        for (int c = 0; c < 11; c++) begin
            inValid[2]  = (c < 9);
            outReady[2] = (c >= 2);
            inCtrl[2]   = 16'h0D00 + 16'(c + 1);
            inData[2]   = 32'hD000_0000 + 32'(c + 1);
            #1;
            h = headOf();
            total++; if (outValid[2] !== (mq.size() != 0)) begin bad++; $display("[TB] FAIL wrap_valid c%0d: got %b", c, outValid[2]); end
            total++; if (outData[2] !== h[31:0]) begin bad++; $display("[TB] FAIL wrap_data c%0d: got %h want %h", c, outData[2], h[31:0]); end
            total++; if (outCtrl[2] !== h[47:32]) begin bad++; $display("[TB] FAIL wrap_ctrl c%0d: got %h want %h", c, outCtrl[2], h[47:32]); end
            total++; if (occ[2] !== 4'(mq.size())) begin bad++; $display("[TB] FAIL wrap_occ c%0d: got %0d want %0d", c, occ[2], mq.size()); end
            stepCycle(2);
        end
        idleInputs();
    endtask

    task automatic test_saturation();
        outReady[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            total++; if (bub[2] !== 16'(expBub[2])) begin bad++; $display("[TB] FAIL sat_bub c%0d: got %0d want %0d", c, bub[2], expBub[2]); end
            stepCycle(2);
        end
        #1;
        total++; if (bub[2] !== 16'd15) begin bad++; $display("[TB] FAIL sat_final: got %0d want 15", bub[2]); end
        idleInputs();
    endtask

    task automatic test_random(input int d, input int n);
        logic [47:0] h;
        bit          wantReady;
        for (int c = 0; c < n; c++) begin
            inValid[d]  = ($urandom_range(0, 3) != 0);
            outReady[d] = ($urandom_range(0, 3) != 0);
            flush[d]    = ($urandom_range(0, 15) == 0);
            inCtrl[d]   = 16'($urandom);
            inData[d]   = $urandom;
            #1;
            h = headOf();
            wantReady = !flush[d] && ((mq.size() < depthOf(d)) || outReady[d]);
            total++; if (outValid[d] !== (mq.size() != 0)) begin bad++; $display("[TB] FAIL rnd%0d_valid c%0d: got %b", d, c, outValid[d]); end
            total++; if (outCtrl[d] !== h[47:32]) begin bad++; $display("[TB] FAIL rnd%0d_ctrl c%0d: got %h want %h", d, c, outCtrl[d], h[47:32]); end
            total++; if (outData[d] !== h[31:0]) begin bad++; $display("[TB] FAIL rnd%0d_data c%0d: got %h want %h", d, c, outData[d], h[31:0]); end
            total++; if (occ[d] !== 4'(mq.size())) begin bad++; $display("[TB] FAIL rnd%0d_occ c%0d: got %0d want %0d", d, c, occ[d], mq.size()); end
            total++; if (inReady[d] !== wantReady) begin bad++; $display("[TB] FAIL rnd%0d_in_ready c%0d: got %b want %b", d, c, inReady[d], wantReady); end
            total++; if (bub[d] !== 16'(expBub[d])) begin bad++; $display("[TB] FAIL rnd%0d_bub c%0d: got %0d want %0d", d, c, bub[d], expBub[d]); end
            stepCycle(d);
        end
        idleInputs();
        flush[d] = 1'b1;
        stepCycle(d);
        flush[d] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_legacy();
        test_wrap();
        test_saturation();
        test_random(0, 250);
        test_random(2, 250);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed ID/EX stage register: one pipeline stage register, generalised in width and depth.
- Holds DEPTH entries in a FIFO. Each entry is a control field and a data field.
- Adds valid/ready handshake, synchronous flush, NOP-bubble insertion and a saturating bubble counter.
- Sits between any two pipeline stages. With DEPTH=1 and out_ready driven as the inverse of the downstream stall, it replaces the legacy stall-gated stage register.

Parameters:
- CTRL_W, 16: width of control field; all-zero encodes a NOP.
- DATA_W, 128: width of data payload (PC+4, operands, immediate, register indices).
- DEPTH, 2: number of entries; legal range 1..8, need not be a power of two.
- CNT_W, 16: width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_b  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held entries (branch mispredict, exception).
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage accepts the offered entry this cycle.
- in_ctrl  in  CTRL_W  upstream control signals.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream consumes the head this cycle (not stalled).
- out_ctrl  out  CTRL_W  head control field; zero when out_valid=0.
- out_data  out  DATA_W  head payload; zero when out_valid=0.
- occupancy  out  clog2(DEPTH+1)  number of held entries.
- bubble_count  out  CNT_W  count of cycles downstream was ready but received a bubble.

Behaviour:
- Reset (rst_b=0, asynchronous):
  - count, read pointer, write pointer and bubble_count go to 0.
  - All storage is cleared to 0.
  - out_valid=0, out_ctrl=0, out_data=0.
  - The block leaves reset on the first clk edge after rst_b rises.
  - Reset mid-transfer discards all entries, with no partial output.
- Pop: pop = out_valid && out_ready.
- Push: push = in_valid && in_ready.
- in_ready = !flush && (count<DEPTH || out_ready). The path from out_ready to in_ready is combinational, which lets a full buffer accept an entry in the same cycle it pops one.
- Push/pop outcomes:
  - Push only: entry written at write pointer; write pointer advances modulo DEPTH; count+1.
  - Pop only: read pointer advances modulo DEPTH; count-1.
  - Push and pop together: both pointers advance; count unchanged. This is legal at count=0? No: pop requires out_valid, so a push into an empty buffer is not visible on the outputs until the next cycle.
- Latency and throughput:
  - Latency in to out is 1 cycle minimum.
  - Throughput is 1 entry/cycle while out_ready=1.
- Output rules:
  - out_valid = (count!=0).
  - out_ctrl/out_data come from the entry at the read pointer, gated to zero when count==0. This is the bubble/NOP insertion.
  - While out_valid=1 and out_ready=0, out_ctrl and out_data stay stable until popped.
- Flush:
  - Next edge: count=0 and both pointers return to 0.
  - Any same-cycle push is dropped (flush has priority; in_ready=0 during flush).
  - A same-cycle pop is permitted; the downstream consumes the head.
  - Outputs read zero from the cycle after flush.
- bubble_count:
  - Increments on each edge where out_ready=1 and out_valid=0.
  - Saturates at 2^CNT_W-1.
  - Flush does not clear it; only reset does.
- Overflow/underflow: push with a full buffer and no pop is impossible (in_ready=0). Pop while empty is impossible (out_valid=0).
- Pointer wrap: a pointer at DEPTH-1 returns to 0 on advance.

Test Plan:
- Streaming:
  - Stimulus: DEPTH=2; after reset, push ctrl=0x0001..0x0005 / data=1..5 on consecutive cycles with out_ready=1.
  - Required response: out_valid rises 1 cycle after the first push; entries 1..5 appear on consecutive cycles; occupancy never exceeds 1; bubble_count=1 (the first cycle only).
- Backpressure:
  - Stimulus: hold out_ready=0 and push 3 entries.
  - Required response: entries 1 and 2 accepted; in_ready=0 at occupancy=2; out_data holds 1 steady. Raising out_ready drains 1, 2, 3 in order, with entry 3 accepted in the same cycle 1 pops.
- Flush:
  - Stimulus: at occupancy=2, assert flush together with in_valid=1.
  - Required response: next cycle occupancy=0, out_valid=0, out_ctrl=0, and the offered entry is absent.
- Asynchronous reset:
  - Stimulus: at occupancy=1, pulse rst_b low between edges.
  - Required response: out_valid, out_ctrl, out_data and bubble_count go to 0 immediately, without waiting for a clk edge.
- Legacy mode and wrap:
  - Stimulus (legacy): DEPTH=1, out_ready=!stall, stall for 3 cycles mid-stream.
  - Required response: the output holds the value during the stall, with no loss and no duplication.
  - Stimulus (wrap): DEPTH=3, 7 push/pop cycles.
  - Required response: pointers wrap 2 to 0 and ordering is preserved.
- Saturation:
  - Stimulus: CNT_W=4, out_ready=1, in_valid=0 for 20 cycles.
  - Required response: bubble_count stops at 15.
